// File: rtl/key_pad_emulator_if.sv
// key_pad_emulator_if: press-request handshake and status between a test controller and the keypad emulator.
interface key_pad_emulator_if;
  logic       press_valid;
  logic [3:0] press_code;
  logic       press_ready;
  logic       busy;
  logic       done;
  logic       err;
  modport master (output press_valid, press_code, input press_ready, busy, done, err);
  modport slave (input press_valid, press_code, output press_ready, busy, done, err);
endinterface

// File: rtl/key_pad_emulator.sv
// key_pad_emulator: passive 4x3 keypad model closing a row/column contact on request.
// Define KEY_PAD_BOUNCE_EN to add contact bounce at the start of press and release.
module key_pad_emulator #(
  parameter int HOLD_CYCLES   = 200000,
  parameter int GAP_CYCLES    = 100000,
  parameter int BOUNCE_CYCLES = 1000,
  parameter int BOUNCE_TOGGLE = 100
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [2:0]          i_col,
  output logic [3:0]          o_row,
  key_pad_emulator_if.slave   press
);
  localparam int MAX_HG = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_B  = BOUNCE_CYCLES > BOUNCE_TOGGLE ? BOUNCE_CYCLES : BOUNCE_TOGGLE;
  localparam int CW     = $clog2((MAX_HG > MAX_B ? MAX_HG : MAX_B) + 1);
  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_sel_q, row_sel_d, row_q, row_d;
  logic [2:0]    col_sel_q, col_sel_d;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          accept, code_ok, contact;
  logic [3:0]    key_idx;
  assign accept  = press.press_valid & ready_q;
  assign code_ok = press.press_code < 4'd12;
  // key_idx enumerates keys row-major from R1C1 to R4C3
  assign key_idx = press.press_code == 4'd0  ? 4'd10 :
                   press.press_code == 4'd11 ? 4'd11 : press.press_code - 4'd1;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    row_sel_d = row_sel_q;
    col_sel_d = col_sel_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (accept && code_ok) begin
        state_d   = PRESS;
        row_sel_d = 4'b1000 >> (key_idx / 4'd3);
        col_sel_d = 3'b100 >> (key_idx % 4'd3);
      end
    end else if (state_q == PRESS && cnt_q == CW'(HOLD_CYCLES - 1)) begin
      state_d = RELEASE;
      cnt_d   = '0;
    end else if (state_q == RELEASE && cnt_q == CW'(GAP_CYCLES - 1)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    ready_d = state_q == IDLE && !(accept && code_ok);
    busy_d  = state_d != IDLE;
    done_d  = state_d == RELEASE && cnt_d == CW'(GAP_CYCLES - 1);
    err_d   = accept && !code_ok;
    row_d   = ~(row_sel_d & {4{contact && |(~i_col & col_sel_d)}});
  end
`ifdef KEY_PAD_BOUNCE_EN
  logic [CW-1:0] tog;
  logic          in_win;
  assign tog     = cnt_d / CW'(BOUNCE_TOGGLE);
  assign in_win  = cnt_d < CW'(BOUNCE_CYCLES);
  // press bounce starts open, release bounce starts closed
  assign contact = state_d == PRESS ? (!in_win || tog[0]) : (state_d == RELEASE && in_win && !tog[0]);
`else
  assign contact = state_d == PRESS;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_sel_q <= '0;
      col_sel_q <= '0;
      row_q     <= 4'hF;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_sel_q <= row_sel_d;
      col_sel_q <= col_sel_d;
      row_q     <= row_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign o_row             = row_q;
  assign press.press_ready = ready_q;
  assign press.busy        = busy_q;
  assign press.done        = done_q;
  assign press.err         = err_q;
endmodule

// File: doc/key_pad_emulator.md
Name: key_pad_emulator

Overview:
Behavioural-synthesizable model of the 4x3 matrix keypad, i.e. the passive end of the column-scan/row-sense interface. It accepts "press key N" requests over a valid/ready handshake and closes the matching row/column contact for a programmed hold time, then enforces a release gap. It drives active-low row lines in response to the active-low column strobes produced by the keypad scanner. Used for on-board self-test and closed-loop simulation of the scanner without physical keys.

Parameters:
HOLD_CYCLES, 200000, cycles the contact stays closed per press (4 ms at 50 MHz, longer than one 3 ms scan period); must be >= 1
GAP_CYCLES, 100000, cycles of forced release after each press before the next request is accepted; must be >= 1
BOUNCE_CYCLES, 1000, bounce window length at press and release edges (used only with BOUNCE_EN)
BOUNCE_TOGGLE, 100, contact toggle period inside the bounce window (used only with BOUNCE_EN)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_col  input  3  column strobes from scanner, active-low; bit2=C1, bit1=C2, bit0=C3 (011=C1, 101=C2, 110=C3)
o_row  output  4  row sense lines, active-low; bit3=R1 .. bit0=R4; idle 1111
i_press_valid  input  1  press request valid
i_press_code  input  4  key code: 0-9 digits, 10='*', 11='#'
o_press_ready  output  1  request accepted when valid & ready
o_busy  output  1  high in PRESS or RELEASE
o_done  output  1  one-cycle pulse on the final RELEASE cycle
o_err  output  1  one-cycle pulse when an invalid code (12-15) is accepted

Behaviour:
- Reset (async assert, sync-safe deassert on i_clk): state=IDLE, counter=0, contact open, o_row=1111, o_press_ready=0 during reset and 1 from the first edge after deassertion, o_busy=0, o_done=0, o_err=0. Reset mid-press releases the key immediately (o_row=1111 without waiting for a clock).
- Key map (code -> row,col): 1 R1C1, 2 R1C2, 3 R1C3, 4 R2C1, 5 R2C2, 6 R2C3, 7 R3C1, 8 R3C2, 9 R3C3, 10 R4C1, 0 R4C2, 11 R4C3.
- FSM states IDLE, PRESS, RELEASE.
- IDLE: o_press_ready=1. On valid&ready with code 0-11: latch row/col, close contact, counter=0, go PRESS. With code 12-15: pulse o_err on the next cycle, remain IDLE, ready stays 1, no contact.
- PRESS: o_press_ready=0, o_busy=1; contact closed for exactly HOLD_CYCLES cycles, then open contact, counter=0, go RELEASE.
- RELEASE: contact open for exactly GAP_CYCLES cycles; o_done pulses in the last one; next state IDLE.
- i_press_valid while not ready is ignored; the request is not queued, and i_press_code may change freely.
- Row drive: registered, 1-cycle latency. Each edge: o_row[r] = 0 iff contact closed, r is the latched row, and i_col bit of the latched column == 0; all other bits 1. Non-one-hot i_col (e.g. 000, 111) follows the same rule, with no error.
- Counter width: $clog2 of max(HOLD_CYCLES, GAP_CYCLES)+1; no wrap inside a state.
- Press-to-next-ready latency: HOLD_CYCLES + GAP_CYCLES + 1 cycles after the accepting edge.

Optional Feature:
KEY_PAD_BOUNCE_EN: when defined, the contact state toggles every BOUNCE_TOGGLE cycles during the first BOUNCE_CYCLES of PRESS (starting open) and the first BOUNCE_CYCLES of RELEASE (starting closed). After each window the contact settles to its nominal state. Total PRESS/RELEASE durations are unchanged, and BOUNCE_CYCLES must be < min(HOLD_CYCLES, GAP_CYCLES). When not defined, the contact is ideal and no bounce logic is synthesized.

Test Plan:
- Bench parameters: HOLD_CYCLES=20, GAP_CYCLES=5, BOUNCE_CYCLES=6, BOUNCE_TOGGLE=2.
- Reset, i_col=011, no request -> o_row=1111, o_press_ready=1, o_busy=0 for 50 cycles.
- Press code 5, i_col cycling 011/101/110 every 4 cycles -> o_row=1011 one cycle after each 101 edge, 1111 otherwise. After 20 PRESS cycles o_row=1111, o_done pulses 5 cycles later, ready returns.
- Loop codes 0-11 with the scanner model attached -> scanner output equals each code, incl. 0->R4C2, 10->R4C1, 11->R4C3.
- Code 13 with valid -> o_err one-cycle pulse, o_busy stays 0, o_row stays 1111.
- Assert i_rst_n=0 at PRESS cycle 10 with code 1 and i_col=011 -> o_row=1111 asynchronously. After release the FSM is in IDLE with ready=1.
- With KEY_PAD_BOUNCE_EN, code 9 and i_col held 110 -> o_row bit1 toggles every 2 cycles for the first 6 PRESS cycles, then is steady 0. The mirror pattern appears in RELEASE.
